// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide on magnitudes.
// Optional macro MULDIV_EARLY_OUT_EN: B=0, signed overflow and multiply-by-zero finish one cycle after start.

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_en
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      r_state;
  logic [5:0]      r_count;
  logic [2:0]      r_op;
  logic            r_neg;
  logic            r_special;
  logic [XLEN-1:0] r_special_val;
  logic [XLEN-1:0] r_m;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [4:0]      r_rd;

  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_neg;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic            w_early;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_special_val;

  // Operand decode: MULHSU keeps rs1 signed, the U variants are fully unsigned.
  assign w_is_div   = funct3[2];
  assign w_a_signed = w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~funct3[0] : ~funct3[1];
  assign w_a_neg    = w_a_signed & rs1_val[XLEN-1];
  assign w_b_neg    = w_b_signed & rs2_val[XLEN-1];
  assign w_a_mag    = w_a_neg ? -rs1_val : rs1_val;
  assign w_b_mag    = w_b_neg ? -rs2_val : rs2_val;
  assign w_neg      = (w_is_div & funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_div_zero = w_is_div & (rs2_val == '0);
  assign w_ovf      = w_is_div & ~funct3[0] & (rs1_val == MIN_INT) & (rs2_val == '1);

`ifdef MULDIV_EARLY_OUT_EN
  logic w_mul_zero;
  assign w_mul_zero = ~w_is_div & ((rs1_val == '0) | (rs2_val == '0));
  assign w_special  = w_div_zero | w_ovf | w_mul_zero;
  assign w_early    = w_special;
`else
  assign w_special  = w_div_zero | w_ovf;
  assign w_early    = 1'b0;
`endif

  always_comb begin
    // NOTE: assign a default first so every path drives the signal and no latch is inferred.
    w_special_val = '0;
    if (w_div_zero)
      w_special_val = funct3[1] ? rs1_val : '1;
    else if (w_ovf)
      w_special_val = funct3[1] ? '0 : MIN_INT;
  end

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_val;

  // Multiply: {r_hi, r_lo} holds partial product over the remaining multiplier bits.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);

  // Divide: r_hi is the partial remainder, r_lo shifts dividend bits out and quotient bits in.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_ge    = w_shift >= {1'b0, r_m};
  assign w_diff  = w_shift[XLEN-1:0] - r_m;

  assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo  = r_neg ? -r_lo : r_lo;
  assign w_rem  = r_neg ? -r_hi : r_hi;

  always_comb begin
    w_fix_val = '0;
    case (r_op)
      3'b000:                 w_fix_val = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_val = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_val = w_quo;
      default:                w_fix_val = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_op          <= '0;
      r_neg         <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= '0;
      r_m           <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_rd          <= '0;
      result        <= '0;
      rd_out        <= '0;
    end else begin
      // NOTE: non-blocking updates so every register in this block sees pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op          <= funct3;
            r_neg         <= w_neg;
            r_special     <= w_special;
            r_special_val <= w_special_val;
            r_rd          <= rd_in;
            r_count       <= '0;
            r_hi          <= '0;
            r_m           <= w_is_div ? w_b_mag : w_a_mag;
            r_lo          <= w_is_div ? w_a_mag : w_b_mag;
            if (w_early) begin
              result  <= w_special_val;
              rd_out  <= rd_in;
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_op[2]) begin
            r_hi <= w_ge ? w_diff : w_shift[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_ge};
          end else begin
            {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
          end
          r_count <= r_count + 6'd1;
          if (r_count == LAST_ITER)
            r_state <= S_FIX;
        end
        S_FIX: begin
          result  <= r_special ? r_special_val : w_fix_val;
          rd_out  <= r_rd;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign wb_en = done & (rd_out != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, reset abort, dropped restart and random ops vs a 64-bit arithmetic model.
// Expected latency follows MULDIV_EARLY_OUT_EN when the bench is built with it.

module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        wb_en;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out),
    .wb_en   (wb_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    int          ia;
    int          ib;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

`ifdef MULDIV_EARLY_OUT_EN
  function automatic bit early_case(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2])
      return (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 0) || (b == 0);
  endfunction
`endif

  // Issues one op, optionally re-pulses start at cycle T+repulse, and checks the completion cycle and the one after.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int repulse);
    int lat;
    int glitches;
    lat = 34;
`ifdef MULDIV_EARLY_OUT_EN
    if (early_case(f3, a, b)) lat = 1;
`endif
    funct3  = f3;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    funct3  = f3 ^ 3'b101;
    rs1_val = ~a;
    rs2_val = a ^ b ^ 32'h5A5A_1234;
    rd_in   = ~rd;
    glitches = 0;
    for (int cyc = 1; cyc < lat; cyc++) begin
      start = (cyc == repulse);
      if (done !== 1'b0 || busy !== 1'b1) glitches++;
      tick();
    end
    start = 1'b0;
    check({tag, " busy/done before completion"}, 32'(glitches), 32'd0);
    check({tag, " done"},   {31'b0, done},  32'd1);
    check({tag, " busy"},   {31'b0, busy},  32'd1);
    check({tag, " result"}, result,         exp);
    check({tag, " rd_out"}, {27'b0, rd_out}, {27'b0, rd});
    check({tag, " wb_en"},  {31'b0, wb_en}, {31'b0, (rd != 5'd0)});
    tick();
    check({tag, " done after"},  {31'b0, done},  32'd0);
    check({tag, " busy after"},  {31'b0, busy},  32'd0);
    check({tag, " result held"}, result,         exp);
    check({tag, " wb_en after"}, {31'b0, wb_en}, 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;

    reset   = 1'b1;
    start   = 1'b0;
    funct3  = '0;
    rs1_val = '0;
    rs2_val = '0;
    rd_in   = '0;
    repeat (3) tick();
    check("reset busy",   {31'b0, busy},  32'd0);
    check("reset done",   {31'b0, done},  32'd0);
    check("reset wb_en",  {31'b0, wb_en}, 32'd0);
    check("reset result", result,         32'd0);
    check("reset rd_out", {27'b0, rd_out}, 32'd0);
    reset = 1'b0;
    tick();

    run_op("mul 7*-3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0);
    run_op("mulhu -1*-1",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 0);
    run_op("mulh -1*-1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 0);
    run_op("mulhsu -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 0);
    run_op("mulh min*min",  3'b001, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000, 0);
    run_op("div -20/6",     3'b100, 32'hFFFF_FFEC, 32'h0000_0006, 5'd4,  32'hFFFF_FFFD, 10);
    run_op("rem -20/6 rd0", 3'b110, 32'hFFFF_FFEC, 32'h0000_0006, 5'd0,  32'hFFFF_FFFE, 0);
    run_op("divu 100/7",    3'b101, 32'd100,       32'd7,         5'd31, 32'd14,        0);
    run_op("remu 100/7",    3'b111, 32'd100,       32'd7,         5'd6,  32'd2,         0);
    run_op("divu x/0",      3'b101, 32'h0000_1234, 32'h0000_0000, 5'd10, 32'hFFFF_FFFF, 0);
    run_op("rem x/0",       3'b110, 32'h0000_1234, 32'h0000_0000, 5'd11, 32'h0000_1234, 0);
    run_op("div overflow",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 0);
    run_op("rem overflow",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 0);
    run_op("mul 0*5",       3'b000, 32'h0000_0000, 32'h0000_0005, 5'd14, 32'h0000_0000, 0);

    // Abort a DIV with reset at T+15.
    funct3  = 3'b100;
    rs1_val = 32'hFFFF_FFEC;
    rs2_val = 32'h0000_0006;
    rd_in   = 5'd7;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (14) tick();
    check("pre-reset busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy",   {31'b0, busy},  32'd0);
    check("abort done",   {31'b0, done},  32'd0);
    check("abort wb_en",  {31'b0, wb_en}, 32'd0);
    check("abort result", result,         32'd0);
    check("abort rd_out", {27'b0, rd_out}, 32'd0);
    run_op("post-reset divu", 3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 0);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: a = 32'h0;
        2: b = 32'($urandom_range(1, 15));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op($sformatf("rnd%0d f3=%0d", i, f3), f3, a, b, rd, model(f3, a, b), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
